// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin arbiter and sequencer that shares one SPI
// master between NUM_REQ requesters. A winner's tx word and slave id are
// registered, a single-cycle start is issued, the master's ready handshake is
// tracked, and the received word is returned with a one-hot done pulse.
// Optional feature macro: SPI_ARB_TIMEOUT_EN adds a watchdog on the WAIT
// states that ends a hung transfer with done plus err and rx_data = 0.
module spi_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_CS         = 1,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SID_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data,
    input  logic [NUM_REQ*SID_W-1:0]      req_slave_id,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          err,
    output logic                          busy,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    output logic [SID_W-1:0]              spi_slave_id,
    input  logic                          spi_ready,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   cur_idx;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [PTR_W-1:0]   ptr_after_win;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] cur_onehot;
    logic               timeout_fire;

    // Find the first set request bit at or after ptr, wrapping around.
    always_comb begin : arb_search
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign ptr_after_win = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_onehot    = NUM_REQ'(1) << win_idx;
    assign cur_onehot    = NUM_REQ'(1) << cur_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             err_q;

    assign timed_out    = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // A real ready rise in WAIT_DONE wins over a timeout on the same cycle.
    assign timeout_fire = timed_out &&
                          ((state == S_WAIT_BUSY) ||
                           ((state == S_WAIT_DONE) && !spi_ready));

    // Watchdog counter over both WAIT states and the err flag that rides with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_START) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_fire) begin
                err_q <= 1'b1;
            end else if (state == S_RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout_fire = 1'b0;
    assign err          = 1'b0;

    // Without the watchdog the timeout limit has no effect; the parameter is
    // kept so both builds share one instantiation signature.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Main sequencer: grant, start pulse, ready handshake, completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            cur_idx      <= '0;
            gnt          <= '0;
            done         <= '0;
            rx_data      <= '0;
            busy         <= 1'b0;
            spi_start    <= 1'b0;
            spi_tx_data  <= '0;
            spi_slave_id <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found && spi_ready) begin
                        cur_idx      <= win_idx;
                        ptr          <= ptr_after_win;
                        spi_tx_data  <= req_tx_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        spi_slave_id <= req_slave_id[win_idx*SID_W +: SID_W];
                        gnt          <= win_onehot;
                        spi_start    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    spi_start <= 1'b0;
                    state     <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (timeout_fire) begin
                        rx_data <= '0;
                        done    <= cur_onehot;
                        state   <= S_RESP;
                    end else if (!spi_ready) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (spi_ready) begin
                        rx_data <= spi_rx_data;
                        done    <= cur_onehot;
                        state   <= S_RESP;
                    end else if (timeout_fire) begin
                        rx_data <= '0;
                        done    <= cur_onehot;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
